bmp_pixel_streamer: RTL and testbench
=====================================

Name: bmp_pixel_streamer

Overview:
- Synthesizable successor to the bench-side bitmap loader. Walks a 24-bit BMP pixel array held in byte-wide frame memory and emits pixels in raster order (top row first, left to right) on a valid/ready stream into the detection pipeline.
- Handles BMP bottom-up row storage and 4-byte row padding.
- Parametrised in frame geometry and address width; supports pause (ENABLE) and frame-boundary sideband.

Parameters:
- WIDTH, 640, pixels per row (>=1).
- HEIGHT, 480, rows per frame (>=1).
- ADDR_W, 20, frame-memory byte address width (matches 0x10_0000-byte memory).
- STRIDE, ((WIDTH*3+3)/4)*4, bytes per stored row including padding. Derived localparam; not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run enable; low = pause.
- START  in  1  frame start request, sampled in IDLE.
- DATA_OFFSET  in  ADDR_W  byte address of pixel array (BMP bfOffBits); captured on START.
- MEM_RD  out  1  memory read strobe.
- MEM_ADDR  out  ADDR_W  memory byte address.
- MEM_DATA  in  8  read data, valid exactly one cycle after MEM_RD.
- PIX_VALID  out  1  pixel valid.
- PIX_READY  in  1  downstream ready.
- PIX_DATA  out  24  pixel {R,G,B}.
- PIX_SOF  out  1  first pixel of frame; qualified by PIX_VALID.
- PIX_EOL  out  1  last pixel of row; qualified by PIX_VALID.
- PIX_EOF  out  1  last pixel of frame; qualified by PIX_VALID.
- BUSY  out  1  frame in progress.
- DONE  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs and counters 0. Reset mid-frame abandons the frame with no DONE, and any in-flight read data is discarded.
- States:
  - IDLE: on START=1 capture DATA_OFFSET, set row_base = DATA_OFFSET + (HEIGHT-1)*STRIDE, col_byte = 0, row = 0, col = 0, BUSY = 1, go to RD.
  - RD: three cycles (k = 0,1,2). MEM_RD = 1, MEM_ADDR = row_base + col_byte + k. The byte arriving for k=0/1/2 is latched as B/G/R. After k=2, go to CAP.
  - CAP: latch the R byte, assemble PIX_DATA, go to OUT.
  - OUT: PIX_VALID = 1; PIX_DATA and sideband stay stable until PIX_READY. On accept:
    - Non-last pixel of row: col++, col_byte += 3, go to RD.
    - Last pixel of row (col = WIDTH-1): col = 0, col_byte = 0, row_base -= STRIDE, row++, go to RD.
    - Last pixel of frame (row = HEIGHT-1 and col = WIDTH-1): go to DONE.
  - DONE: DONE = 1 for one cycle, BUSY = 0, go to IDLE.
- Latency and throughput: with START accepted at edge 0, MEM_RD is high in cycles 1–3 and PIX_VALID is first high in cycle 5. With PIX_READY held high and ENABLE high, the pixel period is 5 cycles.
- Sideband:
  - PIX_SOF = (row = 0 and col = 0).
  - PIX_EOL = (col = WIDTH-1).
  - PIX_EOF = PIX_EOL and (row = HEIGHT-1).
  - For WIDTH=1, every pixel has EOL. For a 1x1 frame, SOF, EOL and EOF are all set on the single pixel.
- ENABLE low:
  - In RD, no MEM_RD is issued and k holds. A byte already in flight is still captured.
  - In OUT, the held pixel stays valid and may be accepted.
  - In IDLE, START is ignored.
  - Resuming continues from the same k with no skipped or duplicated reads.
- START while BUSY: ignored. START in the DONE cycle: ignored.
- Address arithmetic is modulo 2^ADDR_W; overflow is not flagged. Padding bytes are never read.

Optional Feature:
- Macro GRAY_EN.
- Defined: PIX_DATA = {Y,Y,Y} with Y = (R + 2*G + B) >> 2, computed from a 10-bit sum and truncated. Y is computed at CAP, so latency and throughput are unchanged.
- Undefined: PIX_DATA = {R,G,B} unmodified.

Test Plan:
- Geometry: WIDTH=2, HEIGHT=2, DATA_OFFSET=0x36, STRIDE=8, memory 0x36..0x45 = 0x00..0x0F. Required: pixels {0x0A,0x09,0x08} SOF, {0x0D,0x0C,0x0B} EOL, {0x02,0x01,0x00}, {0x05,0x04,0x03} EOL+EOF. MEM_ADDR never in 0x3C–0x3D or 0x44–0x45. DONE pulses once.
- Timing: START at edge 0, PIX_READY=1. Required: MEM_RD high in cycles 1–3, PIX_VALID first high in cycle 5, period 5 cycles, BUSY low in the cycle after DONE.
- Backpressure: PIX_READY low for 7 cycles on the second pixel. Required: PIX_VALID and PIX_DATA stable throughout, no MEM_RD while in OUT, no pixel lost or duplicated.
- Pause and restart: ENABLE low for 4 cycles after the first MEM_RD of a pixel. Required: no MEM_RD while paused, reads then resume at offset+1, pixel correct. START asserted while BUSY has no effect.
- Reset: RESET_N low mid-RD of the third pixel, then START. Required: all outputs 0 immediately, no DONE, new frame begins with SOF at top-row address DATA_OFFSET+(HEIGHT-1)*STRIDE.
- GRAY_EN: bytes B=0x30, G=0x20, R=0x10. Required: PIX_DATA = 0x202020. Without the macro: 0x102030.

Source files
------------

// File: rtl/bmp_pixel_streamer.sv
// bmp_pixel_streamer: walks a bottom-up, row-padded 24-bit BMP pixel array in byte-wide memory
// and streams pixels top row first. Define GRAY_EN to emit {Y,Y,Y} luma instead of {R,G,B}.
module bmp_pixel_streamer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 20
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              START,
    input  logic [ADDR_W-1:0] DATA_OFFSET,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    output logic              PIX_VALID,
    input  logic              PIX_READY,
    output logic [23:0]       PIX_DATA,
    output logic              PIX_SOF,
    output logic              PIX_EOL,
    output logic              PIX_EOF,
    output logic              BUSY,
    output logic              DONE
);

    localparam int STRIDE = ((WIDTH * 3 + 3) / 4) * 4;
    localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] TOP_ROW_OFF = ADDR_W'((HEIGHT - 1) * STRIDE);
    localparam logic [ADDR_W-1:0] PIX_BYTES   = ADDR_W'(3);
    localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW    = ROW_W'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_OUT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [1:0]        r_k;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_col_byte;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_rd_pend;
    logic [1:0]        r_rd_k;
    logic [7:0]        r_b;
    logic [7:0]        r_g;
    logic [23:0]       r_pix_data;

    logic              w_last_col;
    logic              w_last_row;
    logic              w_start_ok;
    logic [7:0]        w_r;
    logic [23:0]       w_pix_nx;

    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);
    assign w_start_ok = START && ENABLE;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: each signal driven here gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        MEM_RD     = 1'b0;
        PIX_VALID  = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nx = S_RD;
            end
            S_RD: begin
                BUSY   = 1'b1;
                MEM_RD = ENABLE;
                if (ENABLE && (r_k == 2'd2)) w_state_nx = S_CAP;
            end
            S_CAP: begin
                BUSY       = 1'b1;
                w_state_nx = S_OUT;
            end
            S_OUT: begin
                BUSY      = 1'b1;
                PIX_VALID = 1'b1;
                if (PIX_READY) w_state_nx = (w_last_col && w_last_row) ? S_DONE : S_RD;
            end
            S_DONE: begin
                DONE       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // The R byte (k=2) lands on MEM_DATA exactly during CAP, so it is used straight from the bus.
    assign w_r = MEM_DATA;

`ifdef GRAY_EN
    logic [9:0] w_luma_sum;
    assign w_luma_sum = {2'b00, w_r} + {1'b0, r_g, 1'b0} + {2'b00, r_b};
    assign w_pix_nx   = {3{w_luma_sum[9:2]}};
`else
    assign w_pix_nx = {w_r, r_g, r_b};
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_k        <= 2'd0;
            r_row_base <= '0;
            r_col_byte <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_k     <= 2'd0;
            r_b        <= 8'd0;
            r_g        <= 8'd0;
            r_pix_data <= 24'd0;
        end else begin
            // Track the read issued last cycle so a byte in flight across a pause is still taken.
            r_rd_pend <= MEM_RD;
            r_rd_k    <= r_k;
            if (r_rd_pend && (r_rd_k == 2'd0)) r_b <= MEM_DATA;
            if (r_rd_pend && (r_rd_k == 2'd1)) r_g <= MEM_DATA;

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_row_base <= DATA_OFFSET + TOP_ROW_OFF;
                        r_col_byte <= '0;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_k        <= 2'd0;
                    end
                end
                S_RD: begin
                    if (ENABLE) r_k <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
                end
                S_CAP: begin
                    r_pix_data <= w_pix_nx;
                end
                S_OUT: begin
                    if (PIX_READY) begin
                        if (w_last_col) begin
                            // Rows are stored bottom-up, so the next displayed row sits one stride lower.
                            r_col      <= '0;
                            r_col_byte <= '0;
                            r_row_base <= r_row_base - STRIDE_A;
                            if (!w_last_row) r_row <= r_row + 1'b1;
                        end else begin
                            r_col      <= r_col + 1'b1;
                            r_col_byte <= r_col_byte + PIX_BYTES;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign MEM_ADDR = MEM_RD ? (r_row_base + r_col_byte + ADDR_W'(r_k)) : '0;
    assign PIX_DATA = r_pix_data;
    assign PIX_SOF  = PIX_VALID && (r_row == '0) && (r_col == '0);
    assign PIX_EOL  = PIX_VALID && w_last_col;
    assign PIX_EOF  = PIX_VALID && w_last_col && w_last_row;

endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// tb_bmp_pixel_streamer: exercises 2x2, 3x2 and 1x1 streamers against a raster-order model of a
// bottom-up, padded BMP pixel array; expectations follow GRAY_EN when it is defined.
module tb_bmp_pixel_streamer;

    localparam int AW = 20;

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    typedef struct {
        int         stall;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       sof;
        logic       eol;
        logic       eof;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    // DUT a: 2x2, DUT b: 3x2 (three padding bytes per row), DUT c: 1x1
    logic          a_en, a_start, a_rd, a_valid, a_ready, a_sof, a_eol, a_eof, a_busy, a_done;
    logic [AW-1:0] a_off, a_addr;
    logic [7:0]    a_mdata;
    logic [23:0]   a_pix;
    logic          b_en, b_start, b_rd, b_valid, b_ready, b_sof, b_eol, b_eof, b_busy, b_done;
    logic [AW-1:0] b_off, b_addr;
    logic [7:0]    b_mdata;
    logic [23:0]   b_pix;
    logic          c_en, c_start, c_rd, c_valid, c_ready, c_sof, c_eol, c_eof, c_busy, c_done;
    logic [AW-1:0] c_off, c_addr;
    logic [7:0]    c_mdata;
    logic [23:0]   c_pix;

    bmp_pixel_streamer #(.WIDTH(2), .HEIGHT(2), .ADDR_W(AW)) u_dut_a (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(a_en), .START(a_start), .DATA_OFFSET(a_off),
        .MEM_RD(a_rd), .MEM_ADDR(a_addr), .MEM_DATA(a_mdata), .PIX_VALID(a_valid),
        .PIX_READY(a_ready), .PIX_DATA(a_pix), .PIX_SOF(a_sof), .PIX_EOL(a_eol),
        .PIX_EOF(a_eof), .BUSY(a_busy), .DONE(a_done)
    );

    bmp_pixel_streamer #(.WIDTH(3), .HEIGHT(2), .ADDR_W(AW)) u_dut_b (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(b_en), .START(b_start), .DATA_OFFSET(b_off),
        .MEM_RD(b_rd), .MEM_ADDR(b_addr), .MEM_DATA(b_mdata), .PIX_VALID(b_valid),
        .PIX_READY(b_ready), .PIX_DATA(b_pix), .PIX_SOF(b_sof), .PIX_EOL(b_eol),
        .PIX_EOF(b_eof), .BUSY(b_busy), .DONE(b_done)
    );

    bmp_pixel_streamer #(.WIDTH(1), .HEIGHT(1), .ADDR_W(AW)) u_dut_c (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(c_en), .START(c_start), .DATA_OFFSET(c_off),
        .MEM_RD(c_rd), .MEM_ADDR(c_addr), .MEM_DATA(c_mdata), .PIX_VALID(c_valid),
        .PIX_READY(c_ready), .PIX_DATA(c_pix), .PIX_SOF(c_sof), .PIX_EOL(c_eol),
        .PIX_EOF(c_eof), .BUSY(c_busy), .DONE(c_done)
    );

    // Memory answers one cycle after the strobe; anything else on the bus is junk.
    always @(posedge clk) begin
        a_mdata <= a_rd ? mem[a_addr[11:0]] : 8'hEE;
        b_mdata <= b_rd ? mem[b_addr[11:0]] : 8'hEE;
        c_mdata <= c_rd ? mem[c_addr[11:0]] : 8'hEE;
    end

    pix_t          a_got[$];
    pix_t          b_got[$];
    logic [AW-1:0] a_addrs[$];
    logic [AW-1:0] b_addrs[$];
    int            a_dones = 0;
    int            b_dones = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && a_ready) a_got.push_back({a_pix, a_sof, a_eol, a_eof});
            if (a_rd) a_addrs.push_back(a_addr);
            if (a_done) a_dones++;
            if (b_valid && b_ready) b_got.push_back({b_pix, b_sof, b_eol, b_eof});
            if (b_rd) b_addrs.push_back(b_addr);
            if (b_done) b_dones++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] model_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [7:0] y;
        y = 8'((int'(r) + 2 * int'(g) + int'(b)) / 4);
`ifdef GRAY_EN
        return {y, y, y};
`else
        return {r, g, b};
`endif
    endfunction

    // Reference: rows displayed top-first are stored last; each row starts on a 4-byte boundary.
    pix_t          exp_pix[$];
    logic [AW-1:0] exp_addr[$];

    function automatic void build_model(input int off, input int w, input int h);
        int stride;
        stride = ((w * 3 + 3) / 4) * 4;
        exp_pix.delete();
        exp_addr.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int   base;
                pix_t p;
                base = off + (h - 1 - r) * stride + 3 * c;
                for (int k = 0; k < 3; k++) exp_addr.push_back(AW'(base + k));
                p.data = model_pix(mem[base + 2], mem[base + 1], mem[base]);
                p.sof  = (r == 0) && (c == 0);
                p.eol  = (c == w - 1);
                p.eof  = (c == w - 1) && (r == h - 1);
                exp_pix.push_back(p);
            end
        end
    endfunction

    task automatic compare_frame(input string nm, input pix_t got[$], input logic [AW-1:0] ga[$],
                                 input int off, input int w, input int h);
        int stride;
        int bad;
        build_model(off, w, h);
        stride = ((w * 3 + 3) / 4) * 4;
        check({nm, " pixel count"}, 64'(got.size()), 64'(exp_pix.size()));
        for (int i = 0; i < exp_pix.size() && i < got.size(); i++)
            check($sformatf("%s pixel %0d {data,sof,eol,eof}", nm, i), 64'(got[i]), 64'(exp_pix[i]));
        check({nm, " read count"}, 64'(ga.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < ga.size(); i++)
            check($sformatf("%s read addr %0d", nm, i), 64'(ga[i]), 64'(exp_addr[i]));
        bad = 0;
        foreach (ga[i]) begin
            int rel;
            rel = int'(ga[i]) - off;
            if (rel >= 0 && rel < h * stride && (rel % stride) >= 3 * w) bad++;
        end
        check({nm, " padding reads"}, 64'(bad), 64'd0);
    endtask

    task automatic wait_a_valid(input string nm);
        int n;
        n = 0;
        while (!a_valid && n < 40) begin
            tick();
            n++;
        end
        check({nm, " valid within bound"}, 64'(a_valid), 64'd1);
    endtask

    task automatic wait_a_done(input string nm);
        int n;
        n = 0;
        while (!a_done && n < 80) begin
            tick();
            n++;
        end
        check({nm, " done within bound"}, 64'(a_done), 64'd1);
        tick();
    endtask

    vec_t          vt[4];
    logic [24:1]   s_rd, s_vl, s_by, s_dn, e_rd, e_vl, e_by, e_dn;
    logic [30:1]   p_rd, p_by;
    logic [AW-1:0] p_ad [1:30];
    int            d0, n, off;
    bit            seen;
    logic [23:0]   held;

    initial begin
        a_en = 1'b1; a_start = 1'b0; a_ready = 1'b0; a_off = '0;
        b_en = 1'b1; b_start = 1'b0; b_ready = 1'b0; b_off = '0;
        c_en = 1'b1; c_start = 1'b0; c_ready = 1'b0; c_off = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem[16'h36 + i] = 8'(i);

        vt[0] = '{0, 8'h0A, 8'h09, 8'h08, 1'b1, 1'b0, 1'b0};
        vt[1] = '{7, 8'h0D, 8'h0C, 8'h0B, 1'b0, 1'b1, 1'b0};
        vt[2] = '{0, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[3] = '{2, 8'h05, 8'h04, 8'h03, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        check("reset outputs", {a_rd, a_addr, a_valid, a_pix, a_sof, a_eol, a_eof, a_busy, a_done}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Geometry and backpressure, table driven
        a_off = AW'(16'h36);
        a_got.delete(); a_addrs.delete(); d0 = a_dones;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_a_valid($sformatf("vec%0d", i));
            held = a_pix;
            for (int s = 0; s < vt[i].stall; s++) begin
                check($sformatf("vec%0d stall%0d valid", i, s), 64'(a_valid), 64'd1);
                check($sformatf("vec%0d stall%0d data stable", i, s), 64'(a_pix), 64'(held));
                check($sformatf("vec%0d stall%0d no read", i, s), 64'(a_rd), 64'd0);
                tick();
            end
            a_ready = 1'b1;
            #1;
            check($sformatf("vec%0d data", i), 64'(a_pix), 64'(model_pix(vt[i].r, vt[i].g, vt[i].b)));
            check($sformatf("vec%0d sof/eol/eof", i), {a_sof, a_eol, a_eof}, {vt[i].sof, vt[i].eol, vt[i].eof});
            tick();
            a_ready = 1'b0;
        end
        wait_a_done("geometry");
        repeat (3) tick();
        check("geometry done pulses", 64'(a_dones - d0), 64'd1);
        check("geometry busy after done", 64'(a_busy), 64'd0);
        compare_frame("geometry", a_got, a_addrs, 'h36, 2, 2);

        // Cycle timing with the sink always ready
        a_ready = 1'b1;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            int p, ph;
            s_rd[c] = a_rd; s_vl[c] = a_valid; s_by[c] = a_busy; s_dn[c] = a_done;
            p = (c - 1) / 5;
            ph = (c - 1) % 5;
            e_rd[c] = (p < 4) && (ph < 3);
            e_vl[c] = (p < 4) && (ph == 4);
            e_by[c] = (c <= 20);
            e_dn[c] = (c == 21);
            tick();
        end
        check("timing MEM_RD cycles 1..24", 64'(s_rd), 64'(e_rd));
        check("timing PIX_VALID cycles 1..24", 64'(s_vl), 64'(e_vl));
        check("timing BUSY cycles 1..24", 64'(s_by), 64'(e_by));
        check("timing DONE cycles 1..24", 64'(s_dn), 64'(e_dn));

        // Pause after the first read of pixel 1, START pokes while busy and in the DONE cycle
        build_model('h36, 2, 2);
        a_got.delete(); a_addrs.delete(); d0 = a_dones;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            a_en = !(c >= 7 && c <= 10);
            a_start = (c == 3) || (c == 8) || (c == 25);
            #1;
            p_rd[c] = a_rd; p_by[c] = a_busy; p_ad[c] = a_addr;
            tick();
        end
        a_en = 1'b1; a_start = 1'b0;
        check("pause first read addr", 64'(p_ad[6]), 64'(exp_addr[3]));
        check("pause no reads while disabled", 64'(p_rd[10:7]), 64'd0);
        check("pause resume read strobe", 64'(p_rd[11]), 64'd1);
        check("pause resume addr k=1", 64'(p_ad[11]), 64'(exp_addr[4]));
        check("pause resume addr k=2", 64'(p_ad[12]), 64'(exp_addr[5]));
        check("start in DONE cycle ignored", 64'(p_by[27]), 64'd0);
        check("pause done pulses", 64'(a_dones - d0), 64'd1);
        compare_frame("pause", a_got, a_addrs, 'h36, 2, 2);

        a_en = 1'b0; a_start = 1'b1;
        repeat (3) tick();
        check("start ignored when disabled", {a_busy, a_rd}, 64'd0);
        a_en = 1'b1; a_start = 1'b0;
        tick();

        // Reset in the middle of reading the third pixel
        d0 = a_dones;
        a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (11) tick();
        check("reset taken mid-read", 64'(a_rd), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {a_rd, a_addr, a_valid, a_pix, a_sof, a_eol, a_eof, a_busy, a_done}, 64'd0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        repeat (10) tick();
        check("no done after reset", 64'(a_dones - d0), 64'd0);
        check("idle after reset", 64'(a_busy), 64'd0);
        a_got.delete(); a_addrs.delete(); d0 = a_dones;
        a_start = 1'b1; tick(); a_start = 1'b0;
        check("restart top-row addr", 64'(a_addr), 64'(16'h36 + 8));
        wait_a_done("restart");
        check("restart done pulses", 64'(a_dones - d0), 64'd1);
        check("restart first pixel sof", 64'(a_got.size() > 0 ? a_got[0].sof : 1'b0), 64'd1);
        compare_frame("restart", a_got, a_addrs, 'h36, 2, 2);
        a_ready = 1'b0;

        // Randomised frames on the padded 3x2 geometry
        for (int f = 0; f < 8; f++) begin
            off = int'($urandom_range(0, 'h300));
            for (int i = 0; i < 24; i++) mem[off + i] = 8'($urandom);
            b_off = AW'(off);
            b_got.delete(); b_addrs.delete(); d0 = b_dones;
            b_en = 1'b1; b_start = 1'b1; tick();
            b_start = 1'b0; b_off = AW'($urandom);
            n = 0; seen = 1'b0;
            while (!seen && n < 400) begin
                b_en = ($urandom_range(0, 3) != 0);
                b_ready = 1'($urandom_range(0, 1));
                b_start = ($urandom_range(0, 5) == 0);
                #1;
                seen = b_done;
                if (!seen) tick();
                n++;
            end
            b_start = 1'b0; b_ready = 1'b0; b_en = 1'b1;
            check($sformatf("random%0d done within bound", f), 64'(seen), 64'd1);
            tick();
            check($sformatf("random%0d done pulses", f), 64'(b_dones - d0), 64'd1);
            compare_frame($sformatf("random%0d", f), b_got, b_addrs, off, 3, 2);
        end

        // 1x1 frame: single pixel carries every sideband flag; luma when GRAY_EN is defined
        mem[16'h100] = 8'h30; mem[16'h101] = 8'h20; mem[16'h102] = 8'h10;
        c_off = AW'(16'h100); c_ready = 1'b1;
        c_start = 1'b1; tick(); c_start = 1'b0;
        n = 0;
        while (!c_valid && n < 20) begin
            tick();
            n++;
        end
        check("1x1 valid within bound", 64'(c_valid), 64'd1);
`ifdef GRAY_EN
        check("1x1 data", 64'(c_pix), 64'h202020);
`else
        check("1x1 data", 64'(c_pix), 64'h102030);
`endif
        check("1x1 sof/eol/eof", {c_sof, c_eol, c_eof}, 64'b111);
        tick();
        check("1x1 done after accept", {c_done, c_busy}, 64'b10);
        tick();
        check("1x1 idle after done", {c_done, c_busy}, 64'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
